// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the ccff configuration-chain loader.
package ccff_loader_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_ld_state_t;

  // CRC-8 over the serial configuration stream (x^8 + x^2 + x + 1).
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/ccff_crc8_serial.sv
// Bit-serial CRC-8 (MSB-first) with synchronous clear and update enable.
// Used by ccff_stream_loader only when CCFF_STREAM_CRC_EN is defined.
module ccff_crc8_serial
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[7] ^ din;

  // Shift one bit into the CRC per enabled cycle; clear takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC8_INIT;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/ccff_stream_loader.sv
// Configuration-chain loader: takes bitstream words over valid/ready,
// serialises them MSB-first onto ccff_head with a per-bit shift_en, and
// frames the load with config_enable / busy / done.
// Optional build macro CCFF_STREAM_CRC_EN adds a CRC-8 of the shifted bits
// on cfg_crc; without it cfg_crc is tied to zero.
module ccff_stream_loader
  import ccff_loader_pkg::*;
#(
  parameter  int CHAIN_LEN = 2,
  parameter  int DATA_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              shift_en,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_left,
  output logic [7:0]        cfg_crc
);

  ccff_ld_state_t    state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nx;
  logic [CNT_W-1:0]  word_cnt;

  // Bits of the next word that actually go into the chain: a whole word,
  // or only the top bits_left MSBs of the final partial word.
  function automatic logic [CNT_W-1:0] word_bits(input logic [CNT_W-1:0] left);
    if (int'(left) >= DATA_W) return CNT_W'(DATA_W);
    return left;
  endfunction

  assign shreg_nx = shreg << 1;

  // Loader FSM. ccff_head/shift_en are registered so that while in SHIFT
  // they present shreg's MSB; the chain takes that bit on the edge that
  // leaves the cycle, which is also when bits_left is decremented.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state         <= IDLE;
      shreg         <= '0;
      bits_left     <= '0;
      word_cnt      <= '0;
      s_ready       <= 1'b0;
      ccff_head     <= 1'b0;
      shift_en      <= 1'b0;
      config_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= LOAD;
            bits_left     <= CNT_W'(CHAIN_LEN);
            config_enable <= 1'b1;
            busy          <= 1'b1;
            s_ready       <= 1'b1;
          end
        end

        LOAD: begin
          if (abort) begin
            state         <= IDLE;
            s_ready       <= 1'b0;
            config_enable <= 1'b0;
            busy          <= 1'b0;
          end else if (s_valid && s_ready) begin
            shreg     <= s_data;
            word_cnt  <= word_bits(bits_left);
            state     <= SHIFT;
            s_ready   <= 1'b0;
            shift_en  <= 1'b1;
            ccff_head <= s_data[DATA_W-1];
          end
        end

        SHIFT: begin
          // The bit on ccff_head is clocked into the chain this edge,
          // even when aborting, so it is always accounted for.
          shreg     <= shreg_nx;
          bits_left <= bits_left - CNT_W'(1);
          word_cnt  <= word_cnt - CNT_W'(1);
          if (abort) begin
            state         <= IDLE;
            shift_en      <= 1'b0;
            ccff_head     <= 1'b0;
            config_enable <= 1'b0;
            busy          <= 1'b0;
          end else if (word_cnt == CNT_W'(1)) begin
            shift_en  <= 1'b0;
            ccff_head <= 1'b0;
            if (bits_left == CNT_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= LOAD;
              s_ready <= 1'b1;
            end
          end else begin
            ccff_head <= shreg_nx[DATA_W-1];
          end
        end

        DONE: begin
          state         <= IDLE;
          config_enable <= 1'b0;
          busy          <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CCFF_STREAM_CRC_EN
  logic crc_clr;

  assign crc_clr = (state == IDLE) && start;

  ccff_crc8_serial u_crc (
    .clk   (prog_clk),
    .rst_n (pReset_n),
    .clr   (crc_clr),
    .en    (shift_en),
    .din   (ccff_head),
    .crc   (cfg_crc)
  );
`else
  assign cfg_crc = 8'h00;
`endif

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Directed bench for ccff_stream_loader: three instances (CHAIN_LEN 12, 2, 8)
// share the clock and reset and are driven from one linear stimulus sequence.
module tb_ccff_stream_loader;

`ifdef CCFF_STREAM_CRC_EN
  localparam logic [7:0] CRC_EXP = 8'h07;
`else
  localparam logic [7:0] CRC_EXP = 8'h00;
`endif

  logic prog_clk = 1'b0;
  logic pReset_n;

  // Instance A: CHAIN_LEN=12, DATA_W=8
  logic       start_a, abort_a, valid_a;
  logic [7:0] data_a;
  logic       ready_a, head_a, shen_a, cfgen_a, busy_a, done_a;
  logic [3:0] left_a;
  logic [7:0] crc_a;

  // Instances B (CHAIN_LEN=2 default) and C (CHAIN_LEN=8) share control
  logic       start_b, abort_b, valid_b;
  logic [7:0] data_b, data_c;
  logic       ready_b, head_b, shen_b, cfgen_b, busy_b, done_b;
  logic [1:0] left_b;
  logic [7:0] crc_b;
  logic       ready_c, head_c, shen_c, cfgen_c, busy_c, done_c;
  logic [3:0] left_c;
  logic [7:0] crc_c;

  int total = 0;
  int bad   = 0;

  logic [15:0] bits;
  int          nshift, ndone, done_k, last_k, stall_err;
  logic [15:0] bits_c;
  int          nshift_c, ndone_c, done_k_c;
  logic [7:0]  crc_at_done;

  always #5 prog_clk = ~prog_clk;

  ccff_stream_loader #(.CHAIN_LEN(12), .DATA_W(8)) u_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_a), .abort(abort_a),
    .s_data(data_a), .s_valid(valid_a), .s_ready(ready_a), .ccff_head(head_a),
    .shift_en(shen_a), .config_enable(cfgen_a), .busy(busy_a), .done(done_a),
    .bits_left(left_a), .cfg_crc(crc_a)
  );

  ccff_stream_loader u_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_b), .abort(abort_b),
    .s_data(data_b), .s_valid(valid_b), .s_ready(ready_b), .ccff_head(head_b),
    .shift_en(shen_b), .config_enable(cfgen_b), .busy(busy_b), .done(done_b),
    .bits_left(left_b), .cfg_crc(crc_b)
  );

  ccff_stream_loader #(.CHAIN_LEN(8), .DATA_W(8)) u_c (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_b), .abort(abort_b),
    .s_data(data_c), .s_valid(valid_b), .s_ready(ready_c), .ccff_head(head_c),
    .shift_en(shen_c), .config_enable(cfgen_c), .busy(busy_c), .done(done_c),
    .bits_left(left_c), .cfg_crc(crc_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic clear_stats();
    bits = '0; nshift = 0; ndone = 0; done_k = -1; last_k = -1;
  endtask

  task automatic sample_a(input int k);
    if (shen_a === 1'b1) begin
      bits   = {bits[14:0], head_a};
      nshift++;
      last_k = k;
    end
    if (done_a === 1'b1) begin
      ndone++;
      done_k = k;
    end
  endtask

  initial begin
    pReset_n = 1'b0;
    start_a = 0; abort_a = 0; valid_a = 0; data_a = 8'h00;
    start_b = 0; abort_b = 0; valid_b = 0; data_b = 8'h00; data_c = 8'h00;

    // ---------------- reset state
    tick(); tick();
    check("rst_ready", ready_a, 0);
    check("rst_head", head_a, 0);
    check("rst_shen", shen_a, 0);
    check("rst_cfgen", cfgen_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_left", left_a, 0);
    check("rst_crc", crc_a, 0);
    #4 pReset_n = 1'b1;
    tick();

    // ---------------- basic load: A5 then 3C, s_valid held
    data_a = 8'hA5; valid_a = 1; start_a = 1;
    tick(); start_a = 0;
    check("ld_ready", ready_a, 1);
    check("ld_cfgen", cfgen_a, 1);
    check("ld_busy", busy_a, 1);
    check("ld_left", left_a, 12);
    check("ld_shen", shen_a, 0);
    tick(); data_a = 8'h3C;
    check("lat_shen", shen_a, 1);
    check("lat_head", head_a, 1);
    clear_stats();
    for (int k = 0; k < 20; k++) begin
      sample_a(k);
      tick();
    end
    valid_a = 0;
    check("basic_bits", bits, 16'h0A53);
    check("basic_nshift", nshift, 12);
    check("basic_ndone", ndone, 1);
    check("basic_done_pos", done_k, last_k + 1);
    check("basic_cfgen_after", cfgen_a, 0);
    check("basic_busy_after", busy_a, 0);
    check("basic_left_after", left_a, 0);

    // ---------------- backpressure between words
    data_a = 8'hA5; valid_a = 1; start_a = 1;
    tick(); start_a = 0;
    tick(); valid_a = 0; data_a = 8'h00;
    clear_stats();
    for (int k = 0; k < 8; k++) begin
      sample_a(k);
      tick();
    end
    check("bp_nshift_w1", nshift, 8);
    check("bp_left", left_a, 4);
    check("bp_ready", ready_a, 1);
    stall_err = 0;
    for (int k = 0; k < 5; k++) begin
      if (shen_a !== 1'b0 || left_a !== 4'd4) stall_err++;
      tick();
    end
    check("bp_stall", stall_err, 0);
    data_a = 8'h3C; valid_a = 1;
    tick(); valid_a = 0; data_a = 8'h00;
    for (int k = 8; k < 16; k++) begin
      sample_a(k);
      tick();
    end
    check("bp_bits", bits, 16'h0A53);
    check("bp_nshift", nshift, 12);
    check("bp_ndone", ndone, 1);

    // ---------------- abort after three shifted bits
    data_a = 8'hA5; valid_a = 1; start_a = 1;
    tick(); start_a = 0;
    tick(); valid_a = 0;
    tick();
    tick();
    abort_a = 1;
    tick(); abort_a = 0;
    check("ab_busy", busy_a, 0);
    check("ab_cfgen", cfgen_a, 0);
    check("ab_shen", shen_a, 0);
    check("ab_ready", ready_a, 0);
    check("ab_left", left_a, 9);
    clear_stats();
    for (int k = 0; k < 4; k++) begin
      sample_a(k);
      tick();
    end
    check("ab_no_done", ndone, 0);
    check("ab_left_hold", left_a, 9);

    // restart; abort in the first LOAD cycle beats a valid word
    data_a = 8'hFF; valid_a = 1; start_a = 1;
    tick(); start_a = 0;
    check("restart_left", left_a, 12);
    check("restart_busy", busy_a, 1);
    abort_a = 1;
    tick(); abort_a = 0; valid_a = 0;
    check("abprio_busy", busy_a, 0);
    check("abprio_shen", shen_a, 0);
    check("abprio_left", left_a, 12);
    tick();
    check("abprio_shen2", shen_a, 0);

    // ---------------- start pulses while busy are ignored
    data_a = 8'hA5; valid_a = 1; start_a = 1;
    tick(); start_a = 0;
    tick(); data_a = 8'h3C;
    clear_stats();
    for (int k = 0; k < 20; k++) begin
      start_a = (k == 1 || k == 9);
      sample_a(k);
      tick();
    end
    start_a = 0; valid_a = 0;
    check("swb_bits", bits, 16'h0A53);
    check("swb_nshift", nshift, 12);
    check("swb_ndone", ndone, 1);
    check("swb_busy", busy_a, 0);

    // ---------------- reset mid-SHIFT
    data_a = 8'hA5; valid_a = 1; start_a = 1;
    tick(); start_a = 0;
    tick(); valid_a = 0;
    tick();
    tick();
    check("mid_shen_pre", shen_a, 1);
    #3 pReset_n = 1'b0;
    #1;
    check("mrst_shen", shen_a, 0);
    check("mrst_head", head_a, 0);
    check("mrst_cfgen", cfgen_a, 0);
    check("mrst_busy", busy_a, 0);
    check("mrst_ready", ready_a, 0);
    check("mrst_left", left_a, 0);
    tick();
    check("mrst_hold", busy_a, 0);
    #4 pReset_n = 1'b1;
    tick();

    // ---------------- CHAIN_LEN=2 (word 0x80) and CHAIN_LEN=8 CRC (word 0x01)
    data_b = 8'h80; data_c = 8'h01; valid_b = 1; start_b = 1;
    tick(); start_b = 0;
    tick(); valid_b = 0;
    clear_stats();
    bits_c = '0; nshift_c = 0; ndone_c = 0; done_k_c = -1; crc_at_done = 8'hXX;
    for (int k = 0; k < 12; k++) begin
      if (shen_b === 1'b1) begin bits = {bits[14:0], head_b}; nshift++; end
      if (done_b === 1'b1) begin ndone++; done_k = k; end
      if (shen_c === 1'b1) begin bits_c = {bits_c[14:0], head_c}; nshift_c++; end
      if (done_c === 1'b1) begin ndone_c++; done_k_c = k; crc_at_done = crc_c; end
      tick();
    end
    check("c2_bits", bits, 16'h0002);
    check("c2_nshift", nshift, 2);
    check("c2_ndone", ndone, 1);
    check("c2_done_pos", done_k, 2);
    check("c2_cfgen", cfgen_b, 0);
    check("c8_bits", bits_c, 16'h0001);
    check("c8_nshift", nshift_c, 8);
    check("c8_done_pos", done_k_c, 8);
    check("c8_crc_done", crc_at_done, CRC_EXP);
    check("c8_crc_stable", crc_c, CRC_EXP);
    check("c2_crc", crc_b, (CRC_EXP == 8'h00) ? 8'h00 : 8'h0E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
